// File: rtl/spi_cmd_sched.sv
// spi_cmd_sched
// Host-side command scheduler placed directly in front of the SPI memory
// controller. Host requests are buffered in a small FIFO and issued to the
// controller one at a time. The scheduler waits for the controller's done
// pulse, or for a watchdog expiry, and returns the result on a valid/ready
// response channel.
//
// Parameters:
//   DEPTH   - request FIFO entries (power of 2, >= 2)
//   TIMEOUT - cycles spent in WAIT without spi_done before the command is aborted
//
// Optional feature macro: SPI_CMD_RETRY_EN
//   When defined, a controller error triggers one automatic retry of the
//   same command. Before the retry, spi_req is held low for one cycle.
//   Timeouts are never retried.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/req_ready           - host request handshake (req_ready = !full)
//   req_wr, req_addr, req_wdata   - request fields (wdata ignored for reads)
//   rsp_valid/rsp_ready           - host response handshake
//   rsp_rdata, rsp_err,
//   rsp_timeout                   - response fields
//   spi_req                       - command valid to the controller
//   spi_wr, spi_addr, spi_din     - command fields to the controller
//   spi_done, spi_err, spi_dout   - controller completion (err/dout qualified by done)
//   busy                          - FIFO non-empty or a transaction in progress

module spi_cmd_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       spi_req,
    output logic       spi_wr,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_din,
    input  logic       spi_done,
    input  logic       spi_err,
    input  logic [7:0] spi_dout,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

`ifdef SPI_CMD_RETRY_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP, RETRY} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

    state_t state, state_n;

    // Request FIFO: each entry is {wr, addr, wdata}
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;
    logic [16:0]   head;

    // Watchdog and next-state values for the registered command/response fields
    logic [WW-1:0] wdog, wdog_n;
    logic          wr_n;
    logic [7:0]    addr_n;
    logic [7:0]    din_n;
    logic [7:0]    rdata_n;
    logic          err_n;
    logic          to_n;
`ifdef SPI_CMD_RETRY_EN
    logic          retry_used, retry_n;
`endif

    assign full      = (count == FULL_CNT);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = mem[rptr];

    assign spi_req   = (state == WAIT);
    assign rsp_valid = (state == RESP);
    assign busy      = (count != '0) || (state != IDLE);

    // FIFO storage is not reset. Emptiness comes from the pointers and the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {req_wr, req_addr, req_wdata};
        end
    end

    // FIFO pointers and occupancy. If a push and a pop happen in the same cycle, the count is unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // State, watchdog and the registered command/response fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wdog        <= '0;
            spi_wr      <= 1'b0;
            spi_addr    <= 8'h00;
            spi_din     <= 8'h00;
            rsp_rdata   <= 8'h00;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
`ifdef SPI_CMD_RETRY_EN
            retry_used  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            wdog        <= wdog_n;
            spi_wr      <= wr_n;
            spi_addr    <= addr_n;
            spi_din     <= din_n;
            rsp_rdata   <= rdata_n;
            rsp_err     <= err_n;
            rsp_timeout <= to_n;
`ifdef SPI_CMD_RETRY_EN
            retry_used  <= retry_n;
`endif
        end
    end

    // Next-state logic. If spi_done arrives in the same cycle the watchdog
    // expires, the done pulse takes priority. Outside WAIT, spi_done is ignored.
    always_comb begin
        state_n = state;
        wdog_n  = wdog;
        wr_n    = spi_wr;
        addr_n  = spi_addr;
        din_n   = spi_din;
        rdata_n = rsp_rdata;
        err_n   = rsp_err;
        to_n    = rsp_timeout;
`ifdef SPI_CMD_RETRY_EN
        retry_n = retry_used;
`endif
        case (state)
            IDLE: begin
                if (pop) begin
                    {wr_n, addr_n, din_n} = head;
                    wdog_n  = '0;
                    state_n = WAIT;
`ifdef SPI_CMD_RETRY_EN
                    retry_n = 1'b0;
`endif
                end
            end
            WAIT: begin
                if (spi_done) begin
                    err_n   = spi_err;
                    to_n    = 1'b0;
                    rdata_n = spi_wr ? 8'h00 : spi_dout;
                    state_n = RESP;
`ifdef SPI_CMD_RETRY_EN
                    if (spi_err && !retry_used) begin
                        retry_n = 1'b1;
                        state_n = RETRY;
                    end
`endif
                end else if (wdog == WD_LAST) begin
                    err_n   = 1'b1;
                    to_n    = 1'b1;
                    rdata_n = 8'h00;
                    state_n = RESP;
                end else begin
                    wdog_n = wdog + WW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
`ifdef SPI_CMD_RETRY_EN
            RETRY: begin
                wdog_n  = '0;
                state_n = WAIT;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// tb_spi_cmd_sched
// Self-checking testbench for spi_cmd_sched using DEPTH=4 and TIMEOUT=16.
// The bench has three parts:
//   - A controller model that completes each command after a chosen number
//     of WAIT cycles, or never completes it, and keeps its own byte memory.
//   - A response sink that applies random backpressure.
//   - A reference model that computes the expected response from the
//     accepted-request order, the controller's chosen outcome and a
//     reference memory.

module tb_spi_cmd_sched;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       spi_req;
    logic       spi_wr;
    logic [7:0] spi_addr;
    logic [7:0] spi_din;
    logic       spi_done;
    logic       spi_err;
    logic [7:0] spi_dout;
    logic       busy;

    always #5 clk = ~clk;

    spi_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .spi_req    (spi_req),
        .spi_wr     (spi_wr),
        .spi_addr   (spi_addr),
        .spi_din    (spi_din),
        .spi_done   (spi_done),
        .spi_err    (spi_err),
        .spi_dout   (spi_dout),
        .busy       (busy)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    // k = WAIT cycle in which done is pulsed (1..TO), or 0 for never
    typedef struct {
        int   k;
        logic err;
    } plan_t;

    req_t  acc_q[$];
    plan_t plan_q[$];
    int    total = 0;
    int    bad   = 0;
    int    issue_idx = 0;
    int    rsp_idx   = 0;
    int    ctrl_mode = 0;
    int    fix_k     = 1;
    logic  fix_err   = 1'b0;
    int    ready_pct = 100;

    logic       ctrl_active = 1'b0;
    int         ctrl_cyc    = 0;
    int         ctrl_r      = 0;
    plan_t      cur_p;
    req_t       cur_r;
    logic [7:0] cmem   [256];
    logic [7:0] refmem [256];
    req_t       sink_r;
    plan_t      sink_p;
    logic       e_err;
    logic       e_to;
    logic [7:0] e_rd;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one request and hold it until accepted; waited = cycles spent blocked
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                                 output int waited);
        logic accepted;
        accepted = 1'b0;
        waited   = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        for (int t = 0; t < 300; t++) begin
            if (req_ready) begin
                acc_q.push_back('{wr: wr, addr: addr, data: data});
                accepted = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checkOutput("drain_timeout", 32'd1, 32'd0);
        end
        checkOutput("all_responded", 32'(rsp_idx), 32'(acc_q.size()));
    endtask

    // Controller model. It also injects spurious done pulses and spurious err values.
    always @(negedge clk) begin
        if (rst) begin
            ctrl_active = 1'b0;
            spi_done    = 1'b0;
            spi_err     = 1'b0;
            spi_dout    = 8'h00;
            issue_idx   = 0;
            plan_q.delete();
            for (int i = 0; i < 256; i++) cmem[i] = 8'h00;
        end else begin
            spi_done = 1'b0;
            spi_err  = 1'($urandom_range(0, 1));
            spi_dout = 8'($urandom);
            if (spi_req) begin
                if (!ctrl_active) begin
                    ctrl_active = 1'b1;
                    ctrl_cyc    = 0;
                    if (ctrl_mode == 1) begin
                        cur_p.k   = 0;
                        cur_p.err = 1'b0;
                    end else if (ctrl_mode == 2) begin
                        cur_p.k   = fix_k;
                        cur_p.err = fix_err;
                    end else begin
                        ctrl_r = int'($urandom_range(0, 9));
                        if (ctrl_r == 0)      cur_p.k = 0;
                        else if (ctrl_r == 1) cur_p.k = TO;
                        else if (ctrl_r == 2) cur_p.k = 1;
                        else                  cur_p.k = int'($urandom_range(1, TO));
                        cur_p.err = ($urandom_range(0, 3) == 0);
                    end
                    plan_q.push_back(cur_p);
                    if (issue_idx < acc_q.size()) begin
                        cur_r = acc_q[issue_idx];
                    end else begin
                        checkOutput("issue_unexpected", 32'd1, 32'd0);
                    end
                    issue_idx++;
                end
                ctrl_cyc++;
                checkOutput("spi_wr", 32'(spi_wr), 32'(cur_r.wr));
                checkOutput("spi_addr", 32'(spi_addr), 32'(cur_r.addr));
                checkOutput("spi_din", 32'(spi_din), 32'(cur_r.data));
                if (cur_p.k != 0 && ctrl_cyc == cur_p.k) begin
                    spi_done = 1'b1;
                    spi_err  = cur_p.err;
                    if (spi_wr) begin
                        if (!cur_p.err) cmem[spi_addr] = spi_din;
                    end else begin
                        spi_dout = cmem[spi_addr];
                    end
                end
            end else begin
                if (ctrl_active) begin
                    ctrl_active = 1'b0;
                    checkOutput("wait_len", 32'(ctrl_cyc), 32'((cur_p.k == 0) ? TO : cur_p.k));
                end
                if ($urandom_range(0, 3) == 0) begin
                    spi_done = 1'b1;
                end
            end
        end
    end

    // Response sink and reference model
    always @(negedge clk) begin
        if (rst) begin
            rsp_ready = 1'b0;
            rsp_idx   = 0;
            for (int i = 0; i < 256; i++) refmem[i] = 8'h00;
        end else begin
            if (rsp_valid) begin
                checkOutput("no_issue_in_resp", 32'(spi_req), 32'd0);
                if (rsp_idx < acc_q.size() && rsp_idx < plan_q.size()) begin
                    sink_r = acc_q[rsp_idx];
                    sink_p = plan_q[rsp_idx];
                    if (sink_p.k == 0) begin
                        e_err = 1'b1;
                        e_to  = 1'b1;
                        e_rd  = 8'h00;
                    end else begin
                        e_err = sink_p.err;
                        e_to  = 1'b0;
                        e_rd  = sink_r.wr ? 8'h00 : refmem[sink_r.addr];
                    end
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e_err));
                    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
                    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
                end else begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < ready_pct);
            if (rsp_valid && rsp_ready && rsp_idx < acc_q.size() && rsp_idx < plan_q.size()) begin
                if (sink_r.wr && sink_p.k != 0 && !sink_p.err) refmem[sink_r.addr] = sink_r.data;
                rsp_idx++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int waited;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;

        // Reset values
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_spi_req", 32'(spi_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_fields", 32'({rsp_rdata, rsp_err, rsp_timeout}), 32'd0);
        checkOutput("rst_spi_fields", 32'({spi_wr, spi_addr, spi_din}), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back
        $display("[TB] write then read");
        ctrl_mode = 2; fix_k = 12; fix_err = 1'b0; ready_pct = 100;
        applyStimulus(1'b1, 8'h10, 8'hA5, waited);
        applyStimulus(1'b0, 8'h10, 8'h3C, waited);
        waitIdle(300);

        // FIFO full with the controller stalled
        $display("[TB] fifo full");
        ctrl_mode = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), waited);
            checkOutput("fifo_accept_wait", 32'(waited), 32'd0);
        end
        @(negedge clk);
        checkOutput("fifo_full_ready", 32'(req_ready), 32'd0);
        applyStimulus(1'b0, 8'h22, 8'h00, waited);
        checkOutput("sixth_blocked", 32'(waited > 0), 32'd1);
        waitIdle(800);

        // Controller error
        $display("[TB] controller error");
        ctrl_mode = 2; fix_k = 5; fix_err = 1'b1;
        applyStimulus(1'b0, 8'hFF, 8'h00, waited);
        waitIdle(200);

        // Response backpressure with spurious done pulses
        $display("[TB] backpressure");
        ctrl_mode = 2; fix_k = 3; fix_err = 1'b0; ready_pct = 0;
        applyStimulus(1'b0, 8'h10, 8'h00, waited);
        applyStimulus(1'b1, 8'h11, 8'h77, waited);
        waited = 0;
        while (!rsp_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (10) @(negedge clk);
        ready_pct = 100;
        waitIdle(300);

        // Randomized traffic
        $display("[TB] random traffic");
        ctrl_mode = 0; ready_pct = 60;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), waited);
        end
        ready_pct = 100;
        waitIdle(3000);

        // Reset in the middle of WAIT with requests queued
        $display("[TB] reset mid-wait");
        ctrl_mode = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'($urandom), 8'h00, waited);
        end
        waited = 0;
        while (!spi_req && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rm_spi_req_before", 32'(spi_req), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rm_spi_req", 32'(spi_req), 32'd0);
        checkOutput("rm_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rm_busy", 32'(busy), 32'd0);
        checkOutput("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        acc_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("rm_busy_after", 32'(busy), 32'd0);
        checkOutput("rm_spi_req_after", 32'(spi_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
